// File: rtl/addsub_serial.sv
// Digit-serial two's complement adder/subtractor: DIGIT bits per clock, NDIG clocks per operation.
// Optional feature: define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] bx_p0;
  logic             carry;
  logic [KW-1:0]    k;

  logic [DIGIT:0]       dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]     raw;
  logic [WIDTH-1:0]     final_ans;
  logic                 cmsb_in;
  logic                 ovf;
  logic                 last;

`ifdef ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                input logic ovf_in,
                                                input logic a_sign);
    logic signed [WIDTH-1:0] res;
    res = val;
    if (ovf_in) begin
      res = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return res;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (k == KLAST);

  // Operands shift right one digit per RUN edge so the active digit is always the low one;
  // result digits enter at the top so the full word is aligned after NDIG edges.
  assign dsum    = {1'b0, a_p0[DIGIT-1:0]} + {1'b0, bx_p0[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign cat     = {dsum[DIGIT-1:0], ans};
  assign raw     = cat[WIDTH+DIGIT-1:DIGIT];
  assign cmsb_in = raw[WIDTH-1] ^ a_p0[DIGIT-1] ^ bx_p0[DIGIT-1];
  assign ovf     = cmsb_in ^ dsum[DIGIT];

`ifdef ADDSUB_SAT_EN
  assign final_ans = saturate(raw, ovf, a_p0[DIGIT-1]);
`else
  assign final_ans = raw;
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_p0  <= a;
      bx_p0 <= b ^ {WIDTH{sub}};
    end else if (state == RUN) begin
      a_p0  <= a_p0 >> DIGIT;
      bx_p0 <= bx_p0 >> DIGIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      k     <= '0;
      ans   <= '0;
      cout  <= 1'b0;
      v     <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      carry <= sub;
      k     <= '0;
    end else if (state == RUN) begin
      carry <= dsum[DIGIT];
      k     <= k + 1'b1;
      if (last) begin
        ans  <= final_ans;
        cout <= dsum[DIGIT];
        v    <= ovf;
        z    <= (final_ans == '0);
        n    <= final_ans[WIDTH-1];
      end else begin
        ans  <= raw;
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=32, DIGIT=8); honours ADDSUB_SAT_EN like the design.
module tb_addsub_serial;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] ans;
  logic             cout, v, z, n;

  int tests = 0;
  int fails = 0;

  addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .ans(ans), .cout(cout), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  // Reference: whole-word integer arithmetic, overflow from operand/result signs.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic msub,
                       output logic [31:0] eans, output logic ec, output logic ev,
                       output logic ez, output logic en);
    logic [32:0] full;
    logic [31:0] r;
    if (msub) full = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
    else      full = {1'b0, ma} + {1'b0, mb};
    r  = full[31:0];
    ec = full[32];
    if (msub) ev = (ma[31] != mb[31]) && (r[31] != ma[31]);
    else      ev = (ma[31] == mb[31]) && (r[31] != ma[31]);
`ifdef ADDSUB_SAT_EN
    if (ev) r = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    eans = r;
    ez   = (r == 32'd0);
    en   = r[31];
  endtask

  // Drives one operation from IDLE, waits dly cycles of backpressure, then consumes it.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic osub,
                        input int dly, output logic [31:0] gans, output logic [3:0] gflags,
                        output int lat, output logic idle_after);
    a = oa; b = ob; sub = osub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (dly) begin @(posedge clk); #1; end
    gans = ans;
    gflags = {cout, v, z, n};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle_after = in_ready && !out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++; $display("FAIL reset_hs: in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
    tests++;
    if ({ans, cout, v, z, n} !== 36'd0) begin
      fails++; $display("FAIL reset_out: ans=%h flags=%b want 0", ans, {cout, v, z, n});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [31:0] va[4] = '{32'h0000_00FF, 32'h336F_B7E5, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vb[4] = '{32'h0000_0001, 32'h336F_B7E5, 32'h0000_0001, 32'h0000_0001};
    logic        vs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    logic [31:0] xa[4] = '{32'h0000_0100, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [3:0]  xf[4] = '{4'b0000, 4'b1010, 4'b0100, 4'b1101};
`else
    logic [31:0] xa[4] = '{32'h0000_0100, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [3:0]  xf[4] = '{4'b0000, 4'b1010, 4'b0101, 4'b1100};
`endif
    logic [31:0] gans;
    logic [3:0]  gf;
    int          lat;
    logic        idl;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], 0, gans, gf, lat, idl);
      tests++;
      if (lat !== NDIG) begin
        fails++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, NDIG);
      end
      tests++;
      if (gans !== xa[i] || gf !== xf[i]) begin
        fails++; $display("FAIL vec%0d_result: ans=%h cvzn=%b want ans=%h cvzn=%b",
                          i, gans, gf, xa[i], xf[i]);
      end
      tests++;
      if (!idl) begin
        fails++; $display("FAIL vec%0d_release: in_ready=%b out_valid=%b want 1 0",
                          i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, eans, gans;
    logic        rs, ec, ev, ez, en, idl;
    logic [3:0]  gf;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
      if (i % 5 == 1) rb = ra;
      if (i % 7 == 2) ra = {ra[31], {31{~ra[31]}}};
      model(ra, rb, rs, eans, ec, ev, ez, en);
      run_op(ra, rb, rs, $urandom_range(0, 3), gans, gf, lat, idl);
      tests++;
      if (lat !== NDIG || gans !== eans || gf !== {ec, ev, ez, en} || !idl) begin
        fails++;
        $display("FAIL rand%0d: a=%h b=%h sub=%b got ans=%h cvzn=%b lat=%0d idle=%b want ans=%h cvzn=%b lat=%0d",
                 i, ra, rb, rs, gans, gf, lat, idl, eans, {ec, ev, ez, en}, NDIG);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] eans, hans;
    logic        ec, ev, ez, en;
    logic [3:0]  hf;
    int          lat;
    model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, eans, ec, ev, ez, en);
    a = 32'h1234_5678; b = 32'h0FED_CBA9; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat !== NDIG) begin
      fails++; $display("FAIL bp_latency: got %0d want %0d", lat, NDIG);
    end
    hans = ans; hf = {cout, v, z, n};
    tests++;
    if (hans !== eans || hf !== {ec, ev, ez, en}) begin
      fails++; $display("FAIL bp_result: ans=%h cvzn=%b want ans=%h cvzn=%b",
                        hans, hf, eans, {ec, ev, ez, en});
    end
    for (int i = 0; i < 5; i++) begin
      a = ~a; b = ~b; sub = ~sub; in_valid = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (ans !== eans || {cout, v, z, n} !== {ec, ev, ez, en} || in_ready !== 1'b0 ||
          out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold%0d: ans=%h cvzn=%b in_ready=%b out_valid=%b want ans=%h cvzn=%b 0 1",
                          i, ans, {cout, v, z, n}, in_ready, out_valid, eans, {ec, ev, ez, en});
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_no_accept: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] gans;
    logic [3:0]  gf;
    int          lat;
    logic        idl, seen;
    out_ready = 1'b1;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ans, cout, v, z, n, out_valid, in_ready} !== 38'b1) begin
      fails++; $display("FAIL midrst_out: ans=%h cvzn=%b out_valid=%b in_ready=%b want 0 0000 0 1",
                        ans, {cout, v, z, n}, out_valid, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL midrst_abandon: out_valid seen=%b want 0", seen);
    end
    run_op(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1, gans, gf, lat, idl);
    tests++;
    if (gans !== 32'h0001_FFFF || gf[3:2] !== 2'b00 || lat !== NDIG) begin
      fails++; $display("FAIL midrst_next: ans=%h cv=%b lat=%0d want ans=0001ffff cv=00 lat=%0d",
                        gans, gf[3:2], lat, NDIG);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT; NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a/b/sub valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH  minuend/addend, two's complement.
REQ-008 SHALL have port b  input  WIDTH  subtrahend/addend, two's complement.
REQ-009 SHALL have port sub  input  1  1 = a-b, 0 = a+b.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port ans  output  WIDTH  result.
REQ-013 SHALL have ports cout, v, z, n  output  1 each  carry-out of MSB, signed overflow, zero, negative.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept edge (IDLE, in_valid=1) SHALL register a, b^{WIDTH{sub}}, carry = sub, clear digit index, go to RUN; later changes on a/b/sub SHALL be ignored.
REQ-016 Each RUN edge SHALL add digit k of A, Bx and carry, store DIGIT result bits, update carry, increment k.
REQ-017 After the edge processing digit NDIG-1, FSM SHALL enter DONE; out_valid SHALL rise exactly NDIG edges after the accept edge.
REQ-018 cout SHALL equal carry out of bit WIDTH-1; v SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (subtract: cout=1 means no borrow).
REQ-019 z SHALL be 1 iff final ans == 0; n SHALL equal final ans[WIDTH-1] (flags computed on post-saturation ans).
REQ-020 In DONE, ans and flags SHALL hold stable until an edge with out_ready=1, then FSM SHALL return to IDLE.
REQ-021 in_valid during RUN/DONE SHALL be ignored (no accept, no effect); a new operation can be accepted no earlier than the edge after the DONE->IDLE edge.
REQ-022 out_ready SHALL be ignored outside DONE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, digit index 0, carry 0, ans 0, cout/v/z/n 0, out_valid 0, in_ready 1 after release.
REQ-024 Reset asserted during RUN or DONE SHALL abandon the operation; no out_valid SHALL follow for it.

Configuration
REQ-025 Macro ADDSUB_SAT_EN defined: when v=1, ans SHALL saturate to most-positive (0111..1) if A[WIDTH-1]=0, else most-negative (1000..0); v and cout still report raw values.
REQ-026 Macro ADDSUB_SAT_EN undefined: ans SHALL be the raw modulo-2^WIDTH result; no saturation logic present.

Verification (WIDTH=32, DIGIT=8, NDIG=4)
REQ-027 a=000000FF, b=00000001, sub=0 -> out_valid 4 edges after accept; ans=00000100, cout=0, v=0, z=0, n=0 (carry crosses digit boundary).
REQ-028 a=336FB7E5, b=336FB7E5, sub=1 -> ans=00000000, z=1, cout=1, v=0, n=0.
REQ-029 a=7FFFFFFF, b=00000001, sub=0 -> v=1, cout=0; ans=80000000, n=1 without macro; ans=7FFFFFFF, n=0 with ADDSUB_SAT_EN.
REQ-030 a=80000000, b=00000001, sub=1 -> v=1, cout=1; ans=7FFFFFFF without macro; ans=80000000, n=1 with ADDSUB_SAT_EN.
REQ-031 Backpressure: out_ready=0 for 5 cycles after out_valid with a/b toggled -> ans/flags unchanged, in_ready=0, second in_valid not accepted; out_ready=1 -> IDLE next edge.
REQ-032 rst_n pulsed low at RUN digit 2 -> outputs immediately 0, out_valid never asserts for that op; next op a=00010000, b=0000FFFF, sub=0 -> ans=0001FFFF, cout=0, v=0.
